// File: rtl/count_driver.sv
// count_driver: initiator for the s/x/g counting handshake.
// A one-cycle go request produces a one-cycle start strobe s. The block then
// drives the increment qualifier x until the counting unit answers with g,
// or until TIMEOUT edges pass in DRIVE.
// It reports the number of x-high edges it issued, or a timeout error.
//
// Ports:
//   clk      rising-edge clock
//   clear_n  asynchronous active-low reset
//   go       start request, sampled only in IDLE
//   gap_en   0: x held high in DRIVE; 1: x alternates 1,0,1,...
//   g        done indication from the counting unit
//   s        start strobe (one cycle)
//   x        increment qualifier
//   busy     high in every state except IDLE
//   done     one-cycle pulse: g received
//   err      one-cycle pulse: timeout
//   pulses   count of x-high edges issued in the last run (saturating)
module count_driver #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             go,
  input  logic             gap_en,
  input  logic             g,
  output logic             s,
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH+1:0] pulses
);

  localparam int unsigned PW = WIDTH + 2;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    START = 5'b00010,
    DRIVE = 5'b00100,
    FIN   = 5'b01000,
    FAIL  = 5'b10000
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pulses_d;
  logic          s_d, x_d, busy_d, done_d, err_d;

  // State, cycle counter and registered outputs
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s       <= 1'b0;
      x       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      pulses  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s       <= s_d;
      x       <= x_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
      pulses  <= pulses_d;
    end
  end

  // Next state plus next values of the registered outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pulses_d = pulses;
    s_d      = 1'b0;
    x_d      = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d  = START;
          cnt_d    = '0;
          pulses_d = '0;
          s_d      = 1'b1;
        end
      end
      START: begin
        state_d = DRIVE;
        x_d     = 1'b1;
      end
      DRIVE: begin
        // g has priority over the timeout on the same edge
        if (g) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          if (x && (pulses != '1)) pulses_d = pulses + PW'(1);
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = FAIL;
            err_d   = 1'b1;
          end else begin
            x_d = gap_en ? ~x : 1'b1;
          end
        end
      end
      FIN:     state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_count_driver.sv
// Testbench for count_driver: randomized runs checked against a run-level
// reference model. A second instance with a narrow pulses field
// exercises saturation.
module tb_count_driver;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned TIMEOUT = 32;
  localparam int unsigned SAT2    = 15;

  logic             clk;
  logic             clear_n;
  logic             go, gap_en, g;
  logic             s, x, busy, done, err;
  logic [WIDTH+1:0] pulses;
  logic             s2, x2, busy2, done2, err2;
  logic [3:0]       pulses2;

  int tests = 0;
  int fails = 0;

  count_driver #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clear_n(clear_n), .go(go), .gap_en(gap_en), .g(g),
    .s(s), .x(x), .busy(busy), .done(done), .err(err), .pulses(pulses)
  );

  count_driver #(.WIDTH(2), .TIMEOUT(TIMEOUT)) dut_sat (
    .clk(clk), .clear_n(clear_n), .go(go), .gap_en(gap_en), .g(g),
    .s(s2), .x(x2), .busy(busy2), .done(done2), .err(err2), .pulses(pulses2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic es, input logic ex,
                           input logic eb, input logic ed, input logic ee,
                           input int unsigned ep);
    chk({tag, " s"},      32'(s),      32'(es));
    chk({tag, " x"},      32'(x),      32'(ex));
    chk({tag, " busy"},   32'(busy),   32'(eb));
    chk({tag, " done"},   32'(done),   32'(ed));
    chk({tag, " err"},    32'(err),    32'(ee));
    chk({tag, " pulses"}, 32'(pulses), ep);
    chk({tag, " pulses_sat"}, 32'(pulses2), (ep > SAT2) ? SAT2 : ep);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete run. gap_mode: 0 = gap off, 1 = gap on, 2 = random per cycle.
  // n_xh >= 0: g raised once n_xh x-high edges have been counted.
  // n_edge > 0: g raised on the n_edge-th DRIVE edge.
  task automatic run(input string tag, input int gap_mode, input int n_xh,
                     input int n_edge, input bit go_noise);
    int unsigned pe;
    int          cnt;
    bit          xe;
    int          res;
    pe = 0; cnt = 0; xe = 1'b1; res = 0;
    go = 1'b1; g = 1'($urandom_range(0, 1)); gap_en = 1'($urandom_range(0, 1));
    tick;
    check_all({tag, "/start"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    go = 1'b0; g = 1'($urandom_range(0, 1));
    tick;
    while (res == 0) begin
      check_all({tag, "/drive"}, 1'b0, xe, 1'b1, 1'b0, 1'b0, pe);
      gap_en = (gap_mode == 2) ? 1'($urandom_range(0, 1)) : (gap_mode == 1);
      go     = go_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      g      = ((n_xh >= 0) && (pe >= n_xh)) || ((n_edge > 0) && (cnt == n_edge - 1));
      tick;
      if (g) res = 1;
      else begin
        if (xe) pe++;
        cnt++;
        if (cnt == TIMEOUT) res = 2;
        else xe = gap_en ? !xe : 1'b1;
      end
    end
    check_all({tag, "/end"}, 1'b0, 1'b0, 1'b1, res == 1, res == 2, pe);
    go = 1'b0; g = 1'b0;
    tick;
    check_all({tag, "/idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pe);
    for (int i = 0; i < 3; i++) begin
      g = 1'($urandom_range(0, 1)); gap_en = 1'($urandom_range(0, 1));
      tick;
      check_all({tag, "/hold"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pe);
    end
  endtask

  initial begin
    clear_n = 1'b0; go = 1'b1; g = 1'b1; gap_en = 1'b0;
    tick;
    tick;
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    clear_n = 1'b1; go = 1'b0; g = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      check_all("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end

    run("nominal",      0, 16, -1, 1'b0);
    run("gapped",       1,  8, -1, 1'b0);
    run("timeout",      0, -1, -1, 1'b0);
    run("g_on_timeout", 0, -1, int'(TIMEOUT), 1'b0);
    run("go_in_drive",  2, 10, -1, 1'b1);

    // Reset in the middle of DRIVE
    go = 1'b1; g = 1'b0; gap_en = 1'b0;
    tick;
    go = 1'b0;
    tick;
    for (int i = 0; i < 5; i++) tick;
    check_all("pre_midreset", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5);
    clear_n = 1'b0;
    #1;
    check_all("midreset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    clear_n = 1'b1;
    check_all("midreset_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    tick;
    check_all("midreset_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run("fresh", 0, 6, -1, 1'b0);

    for (int r = 0; r < 8; r++)
      run("rand", 2, int'($urandom_range(0, 20)), -1, 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
